// File: rtl/lsu_wb_master_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 codes, response error codes
// and the controller state encoding.
package lsu_wb_master_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] LSU_ERR_OK       = 2'b00;
   localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
   localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b10;
   localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational size/alignment decoder: byte lanes and replicated store data,
// load-field extraction with sign/zero extension, misaligned and illegal-funct3 flags.
module lsu_align
   import lsu_wb_master_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  sel,
   output logic [31:0] wb_data,
   output logic [31:0] ext_rdata,
   output logic        misaligned,
   output logic        illegal
);

   logic [31:0] field;

   // The addressed byte/halfword is shifted down to bit 0 before extension.
   assign field = rdata >> {addr_lo, 3'b000};

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      sel        = 4'b0000;
      wb_data    = wdata;
      ext_rdata  = 32'h0;
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            sel       = 4'b0001 << addr_lo;
            wb_data   = {4{wdata[7:0]}};
            ext_rdata = (funct3 == F3_B) ? {{24{field[7]}}, field[7:0]} : {24'h0, field[7:0]};
            illegal   = we && (funct3 == F3_BU);
         end
         F3_H, F3_HU: begin
            sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wb_data    = {2{wdata[15:0]}};
            ext_rdata  = (funct3 == F3_H) ? {{16{field[15]}}, field[15:0]} : {16'h0, field[15:0]};
            misaligned = addr_lo[0];
            illegal    = we && (funct3 == F3_HU);
         end
         F3_W: begin
            sel        = 4'b1111;
            ext_rdata  = rdata;
            misaligned = (addr_lo != 2'b00);
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsu_wb_master.sv
// Load/store unit: accepts one RV32I load/store, runs a single Wishbone cycle on a word
// memory and returns extended load data or an error code; a bus timeout prevents hangs.
module lsu_wb_master
   import lsu_wb_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [2:0]  i_req_funct3,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic [1:0]  o_rsp_err,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   input  logic [31:0] i_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   lsu_state_t    state_q, state_d;
   logic          we_q;
   logic [2:0]    funct3_q;
   logic [1:0]    addr_lo_q;
   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          accept, bus_load;
   logic          stb_d, rsp_valid_d;
   logic [1:0]    rsp_err_d;
   logic [31:0]   rsp_rdata_d;

   logic          a_we;
   logic [2:0]    a_funct3;
   logic [1:0]    a_addr_lo;
   logic [3:0]    a_sel;
   logic [31:0]   a_wb_data, a_ext_rdata;
   logic          a_misaligned, a_illegal;

   assign o_req_ready = (state_q == S_IDLE);
   assign accept      = o_req_ready && i_req_valid;
   assign bus_load    = accept && !a_illegal && !a_misaligned;
   assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

   // The decoder checks the incoming request while idle and the latched one afterwards.
   assign a_we      = o_req_ready ? i_req_we           : we_q;
   assign a_funct3  = o_req_ready ? i_req_funct3       : funct3_q;
   assign a_addr_lo = o_req_ready ? i_req_addr[1:0]    : addr_lo_q;

   lsu_align u_align (
      .we         (a_we),
      .funct3     (a_funct3),
      .addr_lo    (a_addr_lo),
      .wdata      (i_req_wdata),
      .rdata      (i_wb_data),
      .sel        (a_sel),
      .wb_data    (a_wb_data),
      .ext_rdata  (a_ext_rdata),
      .misaligned (a_misaligned),
      .illegal    (a_illegal)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= S_IDLE;
      // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
      else            state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      stb_d       = o_wb_stb;
      rsp_valid_d = 1'b0;
      rsp_err_d   = o_rsp_err;
      rsp_rdata_d = o_rsp_rdata;
      case (state_q)
         S_IDLE: if (accept) begin
            if (a_illegal || a_misaligned) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = a_illegal ? LSU_ERR_ILLEGAL : LSU_ERR_MISALIGN;
               rsp_rdata_d = 32'h0;
            end else begin
               state_d = S_REQ;
               stb_d   = 1'b1;
            end
         end
         S_REQ: if (tmo_hit) begin
            state_d     = S_RESP;
            stb_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = LSU_ERR_TIMEOUT;
            rsp_rdata_d = 32'h0;
         end else if (!i_wb_stall) begin
            state_d = S_WAIT;
            stb_d   = 1'b0;
         end
         S_WAIT: if (i_wb_ack) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = LSU_ERR_OK;
            rsp_rdata_d = we_q ? 32'h0 : a_ext_rdata;
         end else if (tmo_hit) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = LSU_ERR_TIMEOUT;
            rsp_rdata_d = 32'h0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_wb_stb    <= 1'b0;
         o_wb_we     <= 1'b0;
         o_wb_addr   <= 32'h0;
         o_wb_data   <= 32'h0;
         o_wb_sel    <= 4'b0000;
         o_rsp_valid <= 1'b0;
         o_rsp_err   <= LSU_ERR_OK;
         o_rsp_rdata <= 32'h0;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_lo_q   <= 2'b00;
         tmo_cnt     <= '0;
      end else begin
         o_wb_stb    <= stb_d;
         o_rsp_valid <= rsp_valid_d;
         o_rsp_err   <= rsp_err_d;
         o_rsp_rdata <= rsp_rdata_d;
         if (accept) begin
            we_q      <= i_req_we;
            funct3_q  <= i_req_funct3;
            addr_lo_q <= i_req_addr[1:0];
         end
         if (bus_load) begin
            o_wb_we   <= i_req_we;
            o_wb_addr <= {2'b00, i_req_addr[31:2]};
            o_wb_data <= a_wb_data;
            o_wb_sel  <= a_sel;
         end
         // Idle is the only way into S_REQ, so clearing here clears on entry.
         if (state_q == S_IDLE)      tmo_cnt <= '0;
         else if (state_q != S_RESP) tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Self-checking bench for lsu_wb_master against a 3-cycle-ack word memory model
// with a stall control that doubles as a never-acking slave.
module tb_lsu_wb_master;

   localparam int TMO = 8;

   logic        i_clk, i_reset_n;
   logic        i_req_valid, o_req_ready, i_req_we;
   logic [31:0] i_req_addr, i_req_wdata;
   logic [2:0]  i_req_funct3;
   logic        o_rsp_valid;
   logic [31:0] o_rsp_rdata;
   logic [1:0]  o_rsp_err;
   logic        o_wb_stb, o_wb_we;
   logic [31:0] o_wb_addr, o_wb_data;
   logic [3:0]  o_wb_sel;
   logic [31:0] i_wb_data;
   logic        i_wb_ack, i_wb_stall;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          stb_cycles = 0;
   int          rsp_count = 0;
   int          accept_count = 0;
   logic        force_ack;
   logic [2:0]  ack_pipe;
   logic [31:0] rd_q;
   logic [31:0] mem [0:15];

   lsu_wb_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_funct3(i_req_funct3),
      .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
      .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .o_wb_sel(o_wb_sel), .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall)
   );

   always #5 i_clk = ~i_clk;

   // Memory: transfer taken on stb && !stall, ack three cycles later.
   assign i_wb_ack  = ack_pipe[2] | force_ack;
   assign i_wb_data = rd_q;

   always @(posedge i_clk) begin
      ack_pipe <= {ack_pipe[1:0], o_wb_stb & ~i_wb_stall};
      if (o_wb_stb && !i_wb_stall) begin
         accept_count <= accept_count + 1;
         rd_q <= mem[o_wb_addr[3:0]];
         if (o_wb_we)
            for (int l = 0; l < 4; l++)
               if (o_wb_sel[l]) mem[o_wb_addr[3:0]][8*l +: 8] <= o_wb_data[8*l +: 8];
      end
   end

   // Scoreboard: every response pulse pops one expected entry.
   always @(negedge i_clk) begin
      exp_t e;
      if (o_wb_stb === 1'b1) stb_cycles++;
      if (o_rsp_valid === 1'b1) begin
         rsp_count++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got rdata %h err %b, required no response", o_rsp_rdata, o_rsp_err);
         end else begin
            e = sb.pop_front();
            if (o_rsp_rdata !== e.rdata || o_rsp_err !== e.err) begin
               errors++;
               $display("FAIL rsp_data: got rdata %h err %b, required rdata %h err %b",
                        o_rsp_rdata, o_rsp_err, e.rdata, e.err);
            end
         end
      end
   end

   task automatic step();
      @(posedge i_clk); #1;
   endtask

   // Called one step after an edge; returns one step after the accepting edge (cycle 1).
   task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [31:0] er, input logic [1:0] ee);
      exp_t e;
      int   n = 0;
      i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wdata; i_req_funct3 = f3;
      while (o_req_ready !== 1'b1 && n < 50) begin step(); n++; end
      checks++;
      if (o_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_wait: ready %b after %0d cycles, required 1", o_req_ready, n);
      end
      e.rdata = er; e.err = ee;
      sb.push_back(e);
      step();
      i_req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string name, output int cyc);
      cyc = 0;
      while (o_rsp_valid !== 1'b1 && cyc < 200) begin step(); cyc++; end
      checks++;
      if (o_rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_rsp_wait: no rsp_valid after %0d cycles, required a pulse", name, cyc);
      end
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      step();
      checks += 9;
      if (o_req_ready !== 1'b1)     begin errors++; $display("FAIL reset_ready: got %b, required 1", o_req_ready); end
      if (o_wb_stb !== 1'b0)        begin errors++; $display("FAIL reset_stb: got %b, required 0", o_wb_stb); end
      if (o_wb_we !== 1'b0)         begin errors++; $display("FAIL reset_we: got %b, required 0", o_wb_we); end
      if (o_wb_sel !== 4'b0000)     begin errors++; $display("FAIL reset_sel: got %b, required 0000", o_wb_sel); end
      if (o_wb_addr !== 32'h0)      begin errors++; $display("FAIL reset_addr: got %h, required 0", o_wb_addr); end
      if (o_wb_data !== 32'h0)      begin errors++; $display("FAIL reset_wdata: got %h, required 0", o_wb_data); end
      if (o_rsp_valid !== 1'b0)     begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", o_rsp_valid); end
      if (o_rsp_err !== 2'b00)      begin errors++; $display("FAIL reset_rsp_err: got %b, required 00", o_rsp_err); end
      if (o_rsp_rdata !== 32'h0)    begin errors++; $display("FAIL reset_rsp_rdata: got %h, required 0", o_rsp_rdata); end
      step(); step();
      i_reset_n = 1'b1;
      step();
   endtask

   task automatic test_loads();
      logic [31:0] t_addr [7] = '{32'h4, 32'h4, 32'h6, 32'h6, 32'h4, 32'h7, 32'h5};
      logic [2:0]  t_f3   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100};
      logic [31:0] t_exp  [7] = '{32'hFFFF_FFF3, 32'h0000_00F3, 32'hFFFF_8081, 32'h0000_8081,
                                  32'h8081_82F3, 32'hFFFF_FF80, 32'h0000_0082};
      logic [3:0]  t_sel  [7] = '{4'b0001, 4'b0001, 4'b1100, 4'b1100, 4'b1111, 4'b1000, 4'b0010};
      int cyc;
      for (int i = 0; i < 7; i++) begin
         send(1'b0, t_addr[i], 32'h0, t_f3[i], t_exp[i], 2'b00);
         checks += 3;
         if (o_wb_stb !== 1'b1)    begin errors++; $display("FAIL load%0d_stb: got %b, required 1", i, o_wb_stb); end
         if (o_wb_sel !== t_sel[i]) begin errors++; $display("FAIL load%0d_sel: got %b, required %b", i, o_wb_sel, t_sel[i]); end
         if (o_wb_addr !== 32'h1)  begin errors++; $display("FAIL load%0d_addr: got %h, required 1", i, o_wb_addr); end
         wait_rsp("load", cyc);
         checks++;
         if (cyc != 4) begin errors++; $display("FAIL load%0d_latency: got %0d, required 4", i, cyc); end
         step();
      end
   endtask

   task automatic test_store_then_load();
      int cyc;
      send(1'b1, 32'h6, 32'h0000_00AB, 3'b000, 32'h0, 2'b00);
      checks += 4;
      if (o_wb_sel !== 4'b0100)      begin errors++; $display("FAIL sb_sel: got %b, required 0100", o_wb_sel); end
      if (o_wb_data !== 32'hABABABAB) begin errors++; $display("FAIL sb_data: got %h, required ABABABAB", o_wb_data); end
      if (o_wb_we !== 1'b1)          begin errors++; $display("FAIL sb_we: got %b, required 1", o_wb_we); end
      if (o_wb_addr !== 32'h1)       begin errors++; $display("FAIL sb_addr: got %h, required 1", o_wb_addr); end
      wait_rsp("sb", cyc); step();
      send(1'b1, 32'h2, 32'hFFFF_1234, 3'b001, 32'h0, 2'b00);
      checks += 2;
      if (o_wb_sel !== 4'b1100)      begin errors++; $display("FAIL sh_sel: got %b, required 1100", o_wb_sel); end
      if (o_wb_data !== 32'h12341234) begin errors++; $display("FAIL sh_data: got %h, required 12341234", o_wb_data); end
      wait_rsp("sh", cyc); step();
      send(1'b1, 32'h8, 32'hDEAD_BEEF, 3'b010, 32'h0, 2'b00);
      checks += 2;
      if (o_wb_sel !== 4'b1111)      begin errors++; $display("FAIL sw_sel: got %b, required 1111", o_wb_sel); end
      if (o_wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data: got %h, required DEADBEEF", o_wb_data); end
      wait_rsp("sw", cyc); step();
      send(1'b0, 32'h4, 32'h0, 3'b010, 32'h80AB_82F3, 2'b00); wait_rsp("lw_after_sb", cyc); step();
      send(1'b0, 32'h0, 32'h0, 3'b010, 32'h1234_0000, 2'b00); wait_rsp("lw_after_sh", cyc); step();
      send(1'b0, 32'h8, 32'h0, 3'b010, 32'hDEAD_BEEF, 2'b00); wait_rsp("lw_after_sw", cyc); step();
   endtask

   task automatic test_errors();
      logic        t_we   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] t_addr [6] = '{32'h5, 32'h3, 32'h4, 32'h4, 32'h1, 32'h2};
      logic [2:0]  t_f3   [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b001, 3'b010};
      logic [1:0]  t_err  [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
      int stb_before;
      for (int i = 0; i < 6; i++) begin
         stb_before = stb_cycles;
         send(t_we[i], t_addr[i], 32'h5555_5555, t_f3[i], 32'h0, t_err[i]);
         checks += 2;
         if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL err%0d_rsp_timing: rsp_valid %b, required 1", i, o_rsp_valid); end
         if (o_wb_stb !== 1'b0)    begin errors++; $display("FAIL err%0d_stb: got %b, required 0", i, o_wb_stb); end
         step();
         checks += 3;
         if (o_req_ready !== 1'b1) begin errors++; $display("FAIL err%0d_ready: got %b, required 1", i, o_req_ready); end
         if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL err%0d_rsp_pulse: got %b, required 0", i, o_rsp_valid); end
         if (stb_cycles != stb_before) begin
            errors++; $display("FAIL err%0d_no_bus: stb cycles %0d, required %0d", i, stb_cycles, stb_before);
         end
      end
   endtask

   task automatic test_timeout();
      int cyc, acc_before, rsp_before;
      acc_before = accept_count;
      i_wb_stall = 1'b1;
      send(1'b0, 32'h4, 32'h0, 3'b010, 32'h0, 2'b11);
      checks++;
      if (o_wb_stb !== 1'b1) begin errors++; $display("FAIL tmo_stb_rise: got %b, required 1", o_wb_stb); end
      wait_rsp("tmo", cyc);
      checks += 2;
      if (cyc != TMO)        begin errors++; $display("FAIL tmo_latency: got %0d, required %0d", cyc, TMO); end
      if (o_wb_stb !== 1'b0) begin errors++; $display("FAIL tmo_stb_drop: got %b, required 0", o_wb_stb); end
      step();
      i_wb_stall = 1'b0;
      checks += 2;
      if (o_req_ready !== 1'b1) begin errors++; $display("FAIL tmo_ready: got %b, required 1", o_req_ready); end
      if (accept_count != acc_before) begin
         errors++; $display("FAIL tmo_no_transfer: transfers %0d, required %0d", accept_count, acc_before);
      end
      rsp_before = rsp_count;
      force_ack = 1'b1; step(); force_ack = 1'b0;
      step(); step(); step();
      checks += 2;
      if (rsp_count != rsp_before) begin errors++; $display("FAIL stray_ack_rsp: pulses %0d, required %0d", rsp_count, rsp_before); end
      if (o_req_ready !== 1'b1)    begin errors++; $display("FAIL stray_ack_ready: got %b, required 1", o_req_ready); end
      send(1'b0, 32'h4, 32'h0, 3'b010, 32'h80AB_82F3, 2'b00); wait_rsp("post_tmo", cyc); step();
   endtask

   task automatic test_stall();
      int cyc, acc_before;
      acc_before = accept_count;
      i_wb_stall = 1'b1;
      send(1'b0, 32'h4, 32'h0, 3'b010, 32'h80AB_82F3, 2'b00);
      for (int c = 1; c <= 4; c++) begin
         checks += 2;
         if (o_wb_stb !== 1'b1)   begin errors++; $display("FAIL stall_c%0d_stb: got %b, required 1", c, o_wb_stb); end
         if (o_wb_addr !== 32'h1) begin errors++; $display("FAIL stall_c%0d_addr: got %h, required 1", c, o_wb_addr); end
         if (c < 4) step();
      end
      i_wb_stall = 1'b0;
      wait_rsp("stall", cyc);
      checks += 2;
      if (cyc != 4) begin errors++; $display("FAIL stall_latency: got %0d, required 4", cyc); end
      if (accept_count != acc_before + 1) begin
         errors++; $display("FAIL stall_one_transfer: transfers %0d, required %0d", accept_count, acc_before + 1);
      end
      step();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   c, rsp_cyc, cyc;
      checks++;
      if (o_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_start_ready: got %b, required 1", o_req_ready); end
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h4; i_req_funct3 = 3'b010;
      e.rdata = 32'h80AB_82F3; e.err = 2'b00; sb.push_back(e);
      step();
      i_req_funct3 = 3'b000;
      c = 1; rsp_cyc = -1;
      while (o_req_ready !== 1'b1 && c < 20) begin
         if (o_rsp_valid === 1'b1) rsp_cyc = c;
         step(); c++;
      end
      checks += 2;
      if (rsp_cyc != 5) begin errors++; $display("FAIL b2b_first_rsp: cycle %0d, required 5", rsp_cyc); end
      if (c != 6)       begin errors++; $display("FAIL b2b_second_accept: ready at cycle %0d, required 6", c); end
      e.rdata = 32'hFFFF_FFF3; e.err = 2'b00; sb.push_back(e);
      step();
      i_req_valid = 1'b0;
      wait_rsp("b2b", cyc);
      checks++;
      if (cyc != 4) begin errors++; $display("FAIL b2b_second_latency: got %0d, required 4", cyc); end
      step();
   endtask

   task automatic test_reset_mid();
      int cyc, rsp_before;
      send(1'b0, 32'h4, 32'h0, 3'b010, 32'h80AB_82F3, 2'b00);
      step();
      #2 i_reset_n = 1'b0;
      #1;
      checks += 3;
      if (o_wb_stb !== 1'b0)    begin errors++; $display("FAIL rst_mid_stb: got %b, required 0", o_wb_stb); end
      if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rsp: got %b, required 0", o_rsp_valid); end
      if (o_req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b, required 1", o_req_ready); end
      sb.delete();
      rsp_before = rsp_count;
      step(); step(); step();
      i_reset_n = 1'b1;
      repeat (5) step();
      checks++;
      if (rsp_count != rsp_before) begin errors++; $display("FAIL rst_mid_no_rsp: pulses %0d, required %0d", rsp_count, rsp_before); end
      send(1'b0, 32'h4, 32'h0, 3'b010, 32'h80AB_82F3, 2'b00);
      wait_rsp("post_rst", cyc);
      checks++;
      if (cyc != 4) begin errors++; $display("FAIL post_rst_latency: got %0d, required 4", cyc); end
      step();
   endtask

   initial begin
      i_clk = 1'b0; i_reset_n = 1'b1;
      i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = 32'h0; i_req_wdata = 32'h0; i_req_funct3 = 3'b000;
      i_wb_stall = 1'b0; force_ack = 1'b0; ack_pipe = 3'b000; rd_q = 32'h0;
      for (int w = 0; w < 16; w++) mem[w] = 32'h0;
      mem[1] = 32'h8081_82F3;
      #2;
      test_reset();
      test_loads();
      test_store_then_load();
      test_errors();
      test_timeout();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      repeat (3) step();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
